fir_stream_adapter: RTL and testbench

FIR_STREAM_ADAPTER -- requirements
Module: fir_stream_adapter

---
 rtl/fir_stream_adapter.sv | 157 +++++++++++++++
 tb/tb_fir_stream_adapter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_adapter.sv
// Stream adapter between a valid/ready sample source, a single-issue FIR
// core (xin/we/running/xout) and a valid/ready result sink. Samples are
// buffered in a small FIFO and issued one at a time. Each result is held
// until the sink takes it. A FIR that stays busy too long sets a sticky
// error flag, and its sample is dropped.
module fir_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_WIDTH-1:0]       fir_xin,
  output logic                        fir_we,
  input  logic                        fir_running,
  input  logic [DATA_WIDTH-1:0]       fir_xout,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err
);
  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam int            LW     = AW + 1;
  localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);
  localparam logic [15:0]   TO_LIM = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, OUT} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q, level_d;
  logic                  push, pop, fifo_empty;

  logic [DATA_WIDTH-1:0] xin_q, xin_d, mdata_q, mdata_d;
  logic                  we_q, we_d, mvalid_q, mvalid_d, err_q, err_d;
  logic [15:0]           cnt_q, cnt_d, cnt_inc;
  logic                  timeout_hit;

  // s_ready depends only on occupancy. It is gated by reset_n so that it
  // reads low while reset is held.
  assign fifo_empty  = (level_q == '0);
  assign s_ready     = reset_n & (level_q != FULL);
  assign push        = s_valid & s_ready;
  assign pop         = (state_q == IDLE) & ~fifo_empty;
  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (cnt_inc == TO_LIM);

  // FIFO storage. It needs no reset because the level and pointers define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // Occupancy next-state. A push and a pop on the same edge cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase
  end

  // FIFO pointers and level. The pointers wrap naturally because the depth
  // is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: the GUARD cycle skips the FIR's late busy rise
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = ISSUE;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (!fir_running)    state_d = OUT;
               else if (timeout_hit) state_d = IDLE;
      OUT:     if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next values of the issue, capture, counter and error registers
  always_comb begin
    xin_d    = xin_q;
    we_d     = 1'b0;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        xin_d = mem_q[rd_ptr_q];
        we_d  = 1'b1;
      end
      GUARD: cnt_d = '0;
      WAIT: begin
        if (!fir_running) begin
          mdata_d  = fir_xout;
          mvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) err_d = 1'b1;
        end
      end
      OUT: if (m_ready) mvalid_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers. The async reset drops fir_we and any held result at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xin_q    <= '0;
      we_q     <= 1'b0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      xin_q    <= xin_d;
      we_q     <= we_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign fir_xin    = xin_q;
  assign fir_we     = we_q;
  assign m_data     = mdata_q;
  assign m_valid    = mvalid_q;
  assign fifo_level = level_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Bench for fir_stream_adapter. A behavioural FIR stub sits on the FIR side.
// The stub either echoes xin or computes a 3-tap filter. Its busy time is
// programmable, and it can be forced to stay busy. Results are checked
// through an expected-value queue.
module tb_fir_stream_adapter;
  localparam int DW = 8, DEPTH = 4, TO = 10;

  logic          clk = 1'b0, reset_n;
  logic [DW-1:0] s_data, fir_xin, fir_xout, m_data;
  logic          s_valid, s_ready, fir_we, fir_running, m_valid, m_ready, err;
  logic [2:0]    fifo_level;

  always #5 clk = ~clk;

  fir_stream_adapter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .fir_xin(fir_xin), .fir_we(fir_we),
    .fir_running(fir_running), .fir_xout(fir_xout), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level), .err(err));

  // y = x[n] + 2*x[n-1] - x[n-2], wrapped to 8 bits
  function automatic logic [7:0] taps(logic signed [7:0] a, logic signed [7:0] b,
                                      logic signed [7:0] c);
    int s;
    s = a + 2 * b - c;
    return s[7:0];
  endfunction

  // ---------------- FIR stub ----------------
  logic       run_q, pend_q, hang;
  int         busy_len, busy_cnt, fir_mode;
  logic [7:0] xout_q;
  logic [7:0] sh [3];
  assign fir_running = run_q | hang;
  assign fir_xout    = xout_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 0; pend_q <= 0; busy_cnt <= 0; xout_q <= 0;
      sh[0] <= 0; sh[1] <= 0; sh[2] <= 0;
    end else if (fir_we) begin
      pend_q <= 1;
      sh[0] <= fir_xin; sh[1] <= sh[0]; sh[2] <= sh[1];
      xout_q <= (fir_mode == 1) ? taps(fir_xin, sh[0], sh[1]) : fir_xin;
    end else if (pend_q) begin
      pend_q <= 0;
      if (busy_len > 0) begin run_q <= 1; busy_cnt <= busy_len - 1; end
    end else if (run_q) begin
      if (busy_cnt == 0) run_q <= 0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;
  int n_push = 0, n_pop = 0, we_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] iss_q [$];
  logic [7:0] mh [3];
  logic       prev_we = 0, prev_mv = 0;
  logic [7:0] prev_md = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_clear();
    exp_q.delete(); iss_q.delete();
    mh[0] = 0; mh[1] = 0; mh[2] = 0;
    prev_we = 0; prev_mv = 0; prev_md = 0;
  endtask

  // One clock. Handshakes are sampled just before the edge and checked #1 after it.
  task automatic step();
    logic pf, mf;
    logic [7:0] sd, md;
    pf = s_valid && s_ready; mf = m_valid && m_ready; sd = s_data; md = m_data;
    @(posedge clk); #1;
    if (pf) begin
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = sd;
      exp_q.push_back(fir_mode == 1 ? taps(mh[0], mh[1], mh[2]) : sd);
      iss_q.push_back(sd);
      n_push++;
    end
    if (mf) begin
      if (exp_q.size() == 0) chk("sb_extra_result", 1, 0);
      else chk("sb_result", md, exp_q.pop_front());
      n_pop++;
    end
    if (fir_we) begin
      we_cnt++;
      if (iss_q.size() == 0) chk("spurious_we", 1, 0);
      else chk("fir_xin", fir_xin, iss_q.pop_front());
      chk("we_while_mvalid", m_valid, 0);
    end
    chk("we_double", fir_we && prev_we, 0);
    chk("level_le_depth", fifo_level <= DEPTH, 1);
    if (prev_mv && m_valid) chk("m_data_stable", m_data, prev_md);
    prev_we = fir_we; prev_mv = m_valid; prev_md = m_data;
  endtask

  typedef struct {
    logic [7:0] x;
    int         busy;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] bv [5];
    logic [7:0] rv [4];
    int w0, n, p0, q0, cyc;
    logic mv_seen;

    // {sample, FIR busy cycles, expected m_data (echo), edges to m_valid}
    tbl[0] = '{8'd37,  3, 8'd37,  7};
    tbl[1] = '{8'hFF,  0, 8'hFF,  4};
    tbl[2] = '{8'd127, 1, 8'd127, 5};
    tbl[3] = '{8'h80,  9, 8'h80, 13};
    tbl[4] = '{8'd0,   2, 8'd0,   6};
    tbl[5] = '{8'd85,  0, 8'd85,  4};
    bv[0] = 8'h9C; bv[1] = 8'd5; bv[2] = 8'd127; bv[3] = 8'h80; bv[4] = 8'd0;
    rv[0] = 8'd11; rv[1] = 8'd22; rv[2] = 8'd33; rv[3] = 8'd44;

    s_valid = 0; s_data = 0; m_ready = 0; hang = 0; busy_len = 0; fir_mode = 0;
    sb_clear();
    reset_n = 1;
    #2 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fir_we", fir_we, 0);
    chk("rst_fir_xin", fir_xin, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_err", err, 0);
    reset_n = 1;
    #1 chk("s_ready_after_rst", s_ready, 1);

    // Table-driven single samples: latency, data, single we pulse, m_valid clear
    for (int i = 0; i < 6; i++) begin
      int lat;
      busy_len = tbl[i].busy; s_data = tbl[i].x; s_valid = 1;
      w0 = we_cnt;
      step();
      s_valid = 0;
      if (i == 0) chk("first_push_level", fifo_level, 1);
      lat = 0;
      while (!m_valid && lat < 40) begin step(); lat++; end
      chk("vec_latency", lat, tbl[i].lat);
      chk("vec_m_data", m_data, tbl[i].exp);
      chk("vec_we_pulses", we_cnt - w0, 1);
      m_ready = 1; step(); m_ready = 0;
      chk("vec_m_valid_clear", m_valid, 0);
    end

    // Burst of 5 samples with the sink stalled, then 20 cycles of backpressure
    busy_len = 0;
    q0 = n_pop;
    for (int k = 0; k < 5; k++) begin
      s_data = bv[k]; s_valid = 1;
      chk("burst_s_ready", s_ready, 1);
      step();
    end
    s_valid = 0;
    chk("burst_level_full", fifo_level, 4);
    chk("burst_s_ready_low", s_ready, 0);
    w0 = we_cnt;
    repeat (20) step();
    chk("bp_m_valid", m_valid, 1);
    chk("bp_no_we", we_cnt - w0, 0);
    chk("bp_level", fifo_level, 4);
    m_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin step(); n++; end
    m_ready = 0;
    chk("burst_drained", exp_q.size(), 0);
    chk("burst_results", n_pop - q0, 5);
    chk("burst_level_empty", fifo_level, 0);

    // Timeout: the FIR stays busy, err sets after TIMEOUT WAIT cycles
    hang = 1;
    s_data = 8'd50; s_valid = 1;
    step();
    s_valid = 0;
    n = 0; mv_seen = 0;
    while (!err && n < 40) begin step(); n++; if (m_valid) mv_seen = 1; end
    chk("timeout_err", err, 1);
    chk("timeout_edges", n, 13);
    chk("timeout_no_mvalid", mv_seen, 0);
    if (exp_q.size() > 0) exp_q.delete(0);   // that result is dropped
    hang = 0;
    w0 = we_cnt;
    s_data = 8'd60; s_valid = 1;
    step();
    s_valid = 0;
    n = 0;
    while (!m_valid && n < 20) begin step(); n++; end
    chk("post_timeout_we", we_cnt - w0, 1);
    chk("post_timeout_m_data", m_data, 60);
    m_ready = 1; step(); m_ready = 0;
    chk("err_sticky", err, 1);

    // Reset while WAIT is active, with 3 samples queued
    busy_len = 8;
    for (int k = 0; k < 4; k++) begin s_data = rv[k]; s_valid = 1; step(); end
    s_valid = 0;
    step(); step();
    chk("prerst_level", fifo_level, 3);
    reset_n = 0;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_fir_we", fir_we, 0);
    chk("midrst_fir_xin", fir_xin, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_err", err, 0);
    sb_clear();
    @(posedge clk); #1;
    reset_n = 1;
    w0 = we_cnt;
    repeat (5) step();
    chk("postrst_level", fifo_level, 0);
    chk("postrst_no_we", we_cnt - w0, 0);

    // Random traffic against the 3-tap filter
    fir_mode = 1;
    p0 = n_push; q0 = n_pop; cyc = 0;
    while ((n_push - p0 < 60 || exp_q.size() != 0) && cyc < 4000) begin
      s_valid  = (n_push - p0 < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_data   = 8'($urandom_range(0, 255));
      m_ready  = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(0, 4);
      step();
      cyc++;
    end
    s_valid = 0; m_ready = 1;
    repeat (10) step();
    m_ready = 0;
    chk("rand_pushed", n_push - p0, 60);
    chk("rand_results", n_pop - q0, 60);
    chk("rand_leftover", exp_q.size(), 0);
    chk("rand_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
